// File: rtl/read_crc_checker.sv
// read_crc_checker
//   Per-burst DDR5 read CRC-8 (x^8+x^2+x+1) checker sitting after the read
//   data manager. Forwards data beats one cycle later. In PHY CRC mode the two
//   trailing CRC beats are checked and stripped; otherwise they are forwarded
//   and not checked. Bursts that stall too long, or that lose en_i, are aborted
//   and flagged as truncated.
//
//   Optional feature macro: CRC_ERR_COUNTER_EN (saturating CRC error counter;
//   when undefined err_count_o is tied to 0).
//
// Ports
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   en_i                  block enable; low forces IDLE (aborts a live burst)
//   rddata_i/_valid_i     incoming read beat and qualifier
//   bl_i                  00=BL16, 01=BC8, 10=BL32, 11=BL16
//   read_crc_enable_i     burst carries 2 trailing CRC beats
//   phy_crc_mode_i        1=check and strip CRC beats, 0=pass them through
//   rd_data_o/_valid_o    forwarded beat, 1-cycle latency
//   crc_done_o            pulse: CRC check of a burst complete
//   crc_err_o             pulse with crc_done_o on mismatch
//   crc_err_sticky_o      set by any CRC error or truncation until reset
//   trunc_err_o           pulse on burst abort
//   err_count_o           saturating CRC error count
module read_crc_checker #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned GAP_TIMEOUT = 16,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  input  logic [DATA_W-1:0]    rddata_i,
  input  logic                 rddata_valid_i,
  input  logic [1:0]           bl_i,
  input  logic                 read_crc_enable_i,
  input  logic                 phy_crc_mode_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic                 rd_data_valid_o,
  output logic                 crc_done_o,
  output logic                 crc_err_o,
  output logic                 crc_err_sticky_o,
  output logic                 trunc_err_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int unsigned GapW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StCrc0, StCrc1} state_e;

  // One byte through CRC-8 poly 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  state_e          state_q;
  logic [5:0]      beat_cnt_q;
  logic [GapW-1:0] gap_cnt_q;
  logic [7:0]      crc_q;
  logic [1:0]      bl_q;
  logic            crc_en_q;
  logic            phy_mode_q;
  logic            crc0_bad_q;

  logic            beat;
  logic            abort;
  logic [5:0]      n_beats;
  logic [5:0]      beat_inc;
  logic [7:0]      crc_upd;

  always_comb begin
    beat     = en_i && rddata_valid_i;
    // A live burst dies on en_i loss or on the GAP_TIMEOUT-th consecutive idle cycle.
    abort    = (state_q != StIdle) &&
               (!en_i || (!rddata_valid_i && (gap_cnt_q == GapW'(GAP_TIMEOUT - 1))));
    beat_inc = beat_cnt_q + 6'd1;
    // First beat of a burst always starts from the 0x00 init value.
    crc_upd  = crc8_byte((state_q == StIdle) ? 8'h00 : crc_q, rddata_i);
    case (bl_q)
      2'b01:   n_beats = 6'd8;
      2'b10:   n_beats = 6'd32;
      default: n_beats = 6'd16;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= StIdle;
      beat_cnt_q       <= '0;
      gap_cnt_q        <= '0;
      crc_q            <= 8'h00;
      bl_q             <= 2'b00;
      crc_en_q         <= 1'b0;
      phy_mode_q       <= 1'b0;
      crc0_bad_q       <= 1'b0;
      rd_data_o        <= '0;
      rd_data_valid_o  <= 1'b0;
      crc_done_o       <= 1'b0;
      crc_err_o        <= 1'b0;
      crc_err_sticky_o <= 1'b0;
      trunc_err_o      <= 1'b0;
    end else begin
      rd_data_valid_o <= 1'b0;
      crc_done_o      <= 1'b0;
      crc_err_o       <= 1'b0;
      trunc_err_o     <= 1'b0;
      if (abort) begin
        state_q          <= StIdle;
        beat_cnt_q       <= '0;
        gap_cnt_q        <= '0;
        trunc_err_o      <= 1'b1;
        crc_err_sticky_o <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            gap_cnt_q <= '0;
            if (beat) begin
              bl_q            <= bl_i;
              crc_en_q        <= read_crc_enable_i;
              phy_mode_q      <= phy_crc_mode_i;
              crc_q           <= crc_upd;
              beat_cnt_q      <= 6'd1;
              rd_data_o       <= rddata_i;
              rd_data_valid_o <= 1'b1;
              state_q         <= StData;
            end
          end
          StData: begin
            if (beat) begin
              gap_cnt_q       <= '0;
              crc_q           <= crc_upd;
              beat_cnt_q      <= beat_inc;
              rd_data_o       <= rddata_i;
              rd_data_valid_o <= 1'b1;
              if (beat_inc == n_beats) begin
                state_q <= crc_en_q ? StCrc0 : StIdle;
                if (!crc_en_q) beat_cnt_q <= '0;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GapW'(1);
            end
          end
          StCrc0: begin
            if (beat) begin
              gap_cnt_q  <= '0;
              crc0_bad_q <= phy_mode_q && (rddata_i != crc_q);
              state_q    <= StCrc1;
              if (!phy_mode_q) begin
                rd_data_o       <= rddata_i;
                rd_data_valid_o <= 1'b1;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GapW'(1);
            end
          end
          StCrc1: begin
            if (beat) begin
              gap_cnt_q  <= '0;
              beat_cnt_q <= '0;
              crc_done_o <= 1'b1;
              state_q    <= StIdle;
              if (phy_mode_q && (crc0_bad_q || (rddata_i != 8'hFF))) begin
                crc_err_o        <= 1'b1;
                crc_err_sticky_o <= 1'b1;
              end
              if (!phy_mode_q) begin
                rd_data_o       <= rddata_i;
                rd_data_valid_o <= 1'b1;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GapW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef CRC_ERR_COUNTER_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_cnt_q <= '0;
    end else if (crc_err_o && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_read_crc_checker.sv
// Directed testbench for read_crc_checker. A negedge monitor logs forwarded
// beats (with cycle stamps) and pulse events; each test task drives a burst and
// compares the logs against expectations it builds itself.
module tb_read_crc_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] rddata;
  logic       rddata_valid;
  logic [1:0] bl;
  logic       read_crc_enable;
  logic       phy_crc_mode;
  logic [7:0] rd_data;
  logic       rd_data_valid;
  logic       crc_done;
  logic       crc_err;
  logic       crc_err_sticky;
  logic       trunc_err;
  logic [7:0] err_count;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  read_crc_checker #(
    .DATA_W     (8),
    .GAP_TIMEOUT(16),
    .ERR_CNT_W  (8)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .en_i             (en),
    .rddata_i         (rddata),
    .rddata_valid_i   (rddata_valid),
    .bl_i             (bl),
    .read_crc_enable_i(read_crc_enable),
    .phy_crc_mode_i   (phy_crc_mode),
    .rd_data_o        (rd_data),
    .rd_data_valid_o  (rd_data_valid),
    .crc_done_o       (crc_done),
    .crc_err_o        (crc_err),
    .crc_err_sticky_o (crc_err_sticky),
    .trunc_err_o      (trunc_err),
    .err_count_o      (err_count)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  fwd_data_q[$];
  int unsigned fwd_cyc_q[$];
  logic [7:0]  exp_data_q[$];
  int unsigned exp_cyc_q[$];
  int unsigned done_cyc_q[$];
  int unsigned err_pulses   = 0;
  int unsigned err_no_done  = 0;
  int unsigned trunc_pulses = 0;

  always @(negedge clk) begin
    if (rd_data_valid) begin
      fwd_data_q.push_back(rd_data);
      fwd_cyc_q.push_back(cyc);
    end
    if (crc_done) done_cyc_q.push_back(cyc);
    if (crc_err) err_pulses++;
    if (crc_err && !crc_done) err_no_done++;
    if (trunc_err) trunc_pulses++;
  end

`ifdef CRC_ERR_COUNTER_EN
  localparam logic [7:0] ExpCntAfterErr = 8'd1;
`else
  localparam logic [7:0] ExpCntAfterErr = 8'd0;
`endif

  function automatic logic [7:0] model_crc(input logic [7:0] bytes[$]);
    logic [7:0] c = 8'h00;
    foreach (bytes[k]) begin
      c = c ^ bytes[k];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Drive one valid beat; if it should be forwarded, expect it one cycle later.
  task automatic send_beat(input logic [7:0] d, input bit fwd);
    @(posedge clk);
    #1;
    rddata_valid = 1'b1;
    rddata       = d;
    if (fwd) begin
      exp_data_q.push_back(d);
      exp_cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rddata_valid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    fwd_data_q.delete();
    fwd_cyc_q.delete();
    exp_data_q.delete();
    exp_cyc_q.delete();
    done_cyc_q.delete();
    err_pulses   = 0;
    err_no_done  = 0;
    trunc_pulses = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; rddata = 8'h00; rddata_valid = 1'b0;
    bl = 2'b00; read_crc_enable = 1'b1; phy_crc_mode = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rd_data, rd_data_valid, crc_done, crc_err, crc_err_sticky, trunc_err, err_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h required 0",
               {rd_data, rd_data_valid, crc_done, crc_err, crc_err_sticky, trunc_err, err_count});
    end
    @(posedge clk); #1; reset_n = 1'b1;
    idle(2);
    clear_logs();
    // Reset in the middle of a burst: everything clears, no pulses.
    for (int i = 0; i < 5; i++) send_beat(8'hA5, 1'b1);
    @(posedge clk); #1; reset_n = 1'b0; rddata_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rd_data, rd_data_valid, crc_err_sticky, err_count} !== '0) begin
      miscompares++;
      $display("FAIL midburst_reset_outputs: got %0h required 0",
               {rd_data, rd_data_valid, crc_err_sticky, err_count});
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (trunc_pulses !== 0 || done_cyc_q.size() !== 0) begin
      miscompares++;
      $display("FAIL midburst_reset_pulses: got trunc=%0d done=%0d required 0/0",
               trunc_pulses, done_cyc_q.size());
    end
    @(posedge clk); #1; reset_n = 1'b1;
    idle(2);
    clear_logs();
  endtask

  task automatic test_bl16_zero();
    bl = 2'b00; read_crc_enable = 1'b1; phy_crc_mode = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(8'h00, 1'b1);
    send_beat(8'h00, 1'b0);
    send_beat(8'hFF, 1'b0);
    idle(3);
    vectors++;
    if (fwd_data_q.size() !== exp_data_q.size()) begin
      miscompares++;
      $display("FAIL bl16_zero_count: got %0d required %0d", fwd_data_q.size(), exp_data_q.size());
    end
    for (int i = 0; i < exp_data_q.size() && i < fwd_data_q.size(); i++) begin
      vectors++;
      if (fwd_data_q[i] !== exp_data_q[i] || fwd_cyc_q[i] !== exp_cyc_q[i]) begin
        miscompares++;
        $display("FAIL bl16_zero_beat%0d: got %0h@%0d required %0h@%0d", i, fwd_data_q[i],
                 fwd_cyc_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    vectors++;
    if (done_cyc_q.size() !== 1 || err_pulses !== 0) begin
      miscompares++;
      $display("FAIL bl16_zero_done: got done=%0d err=%0d required 1/0", done_cyc_q.size(),
               err_pulses);
    end
    clear_logs();
  endtask

  task automatic test_bc8_passthru();
    logic [7:0] d[$];
    logic [7:0] c;
    bl = 2'b01; read_crc_enable = 1'b1; phy_crc_mode = 1'b0;
    for (int i = 1; i <= 8; i++) d.push_back(8'(8'h11 * i));
    c = model_crc(d);
    foreach (d[i]) send_beat(d[i], 1'b1);
    send_beat(c, 1'b1);
    send_beat(8'hFF, 1'b1);
    idle(3);
    vectors++;
    if (fwd_data_q.size() !== 10) begin
      miscompares++;
      $display("FAIL bc8_count: got %0d required 10", fwd_data_q.size());
    end
    for (int i = 0; i < exp_data_q.size() && i < fwd_data_q.size(); i++) begin
      vectors++;
      if (fwd_data_q[i] !== exp_data_q[i] || fwd_cyc_q[i] !== exp_cyc_q[i]) begin
        miscompares++;
        $display("FAIL bc8_beat%0d: got %0h@%0d required %0h@%0d", i, fwd_data_q[i],
                 fwd_cyc_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    vectors++;
    if (done_cyc_q.size() !== 1 || err_pulses !== 0) begin
      miscompares++;
      $display("FAIL bc8_done: got done=%0d err=%0d required 1/0", done_cyc_q.size(), err_pulses);
    end
    clear_logs();
  endtask

  task automatic test_gap_bl32();
    bl = 2'b10; read_crc_enable = 1'b0; phy_crc_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send_beat(8'(i + 8'h40), 1'b1);
      if (i == 12) idle(5);
    end
    idle(3);
    vectors++;
    if (fwd_data_q.size() !== 32) begin
      miscompares++;
      $display("FAIL bl32_count: got %0d required 32", fwd_data_q.size());
    end
    for (int i = 0; i < exp_data_q.size() && i < fwd_data_q.size(); i++) begin
      vectors++;
      if (fwd_data_q[i] !== exp_data_q[i] || fwd_cyc_q[i] !== exp_cyc_q[i]) begin
        miscompares++;
        $display("FAIL bl32_beat%0d: got %0h@%0d required %0h@%0d", i, fwd_data_q[i],
                 fwd_cyc_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    vectors++;
    if (trunc_pulses !== 0 || done_cyc_q.size() !== 0) begin
      miscompares++;
      $display("FAIL bl32_pulses: got trunc=%0d done=%0d required 0/0", trunc_pulses,
               done_cyc_q.size());
    end
    clear_logs();
  endtask

  task automatic test_trunc();
    bl = 2'b00; read_crc_enable = 1'b1; phy_crc_mode = 1'b1;
    vectors++;
    if (crc_err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL sticky_before_trunc: got %0b required 0", crc_err_sticky);
    end
    for (int i = 0; i < 10; i++) send_beat(8'h3C, 1'b1);
    // 15 idle cycles have been sampled here: must still be alive.
    idle(16);
    @(negedge clk);
    vectors++;
    if (trunc_pulses !== 0) begin
      miscompares++;
      $display("FAIL trunc_early: got %0d pulses required 0", trunc_pulses);
    end
    idle(5);
    vectors++;
    if (trunc_pulses !== 1 || done_cyc_q.size() !== 0 || crc_err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL trunc_gap: got trunc=%0d done=%0d sticky=%0b required 1/0/1", trunc_pulses,
               done_cyc_q.size(), crc_err_sticky);
    end
    vectors++;
    if (err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL trunc_err_count: got %0d required 0", err_count);
    end
    clear_logs();
    for (int i = 0; i < 16; i++) send_beat(8'h00, 1'b1);
    send_beat(8'h00, 1'b0);
    send_beat(8'hFF, 1'b0);
    idle(3);
    vectors++;
    if (done_cyc_q.size() !== 1 || err_pulses !== 0 || trunc_pulses !== 0 ||
        fwd_data_q.size() !== 16) begin
      miscompares++;
      $display("FAIL after_trunc_burst: got done=%0d err=%0d trunc=%0d fwd=%0d required 1/0/0/16",
               done_cyc_q.size(), err_pulses, trunc_pulses, fwd_data_q.size());
    end
    clear_logs();
  endtask

  task automatic test_en_drop();
    bl = 2'b00; read_crc_enable = 1'b1; phy_crc_mode = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(8'h77, 1'b0);
    idle(1);
    en = 1'b1;
    idle(2);
    vectors++;
    if (trunc_pulses !== 0 || fwd_data_q.size() !== 0) begin
      miscompares++;
      $display("FAIL en_low_idle: got trunc=%0d fwd=%0d required 0/0", trunc_pulses,
               fwd_data_q.size());
    end
    for (int i = 0; i < 5; i++) send_beat(8'h5A, 1'b1);
    @(posedge clk); #1; en = 1'b0; rddata_valid = 1'b0;
    idle(2);
    en = 1'b1;
    idle(2);
    vectors++;
    if (trunc_pulses !== 1 || done_cyc_q.size() !== 0 || fwd_data_q.size() !== 5) begin
      miscompares++;
      $display("FAIL en_drop: got trunc=%0d done=%0d fwd=%0d required 1/0/5", trunc_pulses,
               done_cyc_q.size(), fwd_data_q.size());
    end
    clear_logs();
  endtask

  task automatic test_crc_value();
    bl = 2'b00; read_crc_enable = 1'b1; phy_crc_mode = 1'b1;
    // 15 x 0x00 then 0x01 gives CRC 0x07.
    for (int i = 0; i < 15; i++) send_beat(8'h00, 1'b1);
    send_beat(8'h01, 1'b1);
    send_beat(8'h07, 1'b0);
    send_beat(8'hFF, 1'b0);
    idle(3);
    vectors++;
    if (done_cyc_q.size() !== 1 || err_pulses !== 0) begin
      miscompares++;
      $display("FAIL crc07_pass: got done=%0d err=%0d required 1/0", done_cyc_q.size(), err_pulses);
    end
    for (int i = 0; i < 15; i++) send_beat(8'h00, 1'b1);
    send_beat(8'h01, 1'b1);
    send_beat(8'h06, 1'b0);
    send_beat(8'hFF, 1'b0);
    idle(3);
    vectors++;
    if (done_cyc_q.size() !== 2 || err_pulses !== 1 || err_no_done !== 0) begin
      miscompares++;
      $display("FAIL crc06_err: got done=%0d err=%0d err_no_done=%0d required 2/1/0",
               done_cyc_q.size(), err_pulses, err_no_done);
    end
    vectors++;
    if (crc_err_sticky !== 1'b1 || err_count !== ExpCntAfterErr) begin
      miscompares++;
      $display("FAIL crc06_sticky_count: got sticky=%0b count=%0d required 1/%0d", crc_err_sticky,
               err_count, ExpCntAfterErr);
    end
    vectors++;
    if (fwd_data_q.size() !== 32) begin
      miscompares++;
      $display("FAIL crc_value_fwd: got %0d required 32", fwd_data_q.size());
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    bl = 2'b00; read_crc_enable = 1'b1; phy_crc_mode = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 15; i++) send_beat(8'h00, 1'b1);
      send_beat(8'h01, 1'b1);
      send_beat(8'h07, 1'b0);
      send_beat(8'hFF, 1'b0);
    end
    idle(3);
    vectors++;
    if (done_cyc_q.size() !== 2 || err_pulses !== 0) begin
      miscompares++;
      $display("FAIL b2b_done: got done=%0d err=%0d required 2/0", done_cyc_q.size(), err_pulses);
    end else begin
      vectors++;
      if (done_cyc_q[1] - done_cyc_q[0] !== 18) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d required 18", done_cyc_q[1] - done_cyc_q[0]);
      end
    end
    vectors++;
    if (fwd_data_q.size() !== 32) begin
      miscompares++;
      $display("FAIL b2b_fwd: got %0d required 32", fwd_data_q.size());
    end
    for (int i = 0; i < exp_data_q.size() && i < fwd_data_q.size(); i++) begin
      vectors++;
      if (fwd_cyc_q[i] !== exp_cyc_q[i]) begin
        miscompares++;
        $display("FAIL b2b_latency%0d: got %0d required %0d", i, fwd_cyc_q[i], exp_cyc_q[i]);
      end
    end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_bl16_zero();
    test_bc8_passthru();
    test_gap_bl32();
    test_trunc();
    test_en_drop();
    test_crc_value();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
